// File: rtl/count_enable_gen.sv
// count_enable_gen: conditions the run/step/clear buttons and sequences enable/clear pulses
// for the downstream 4-bit counter, including a programmable prescaler in RUN mode.
//
// state | meaning
// STOP  | idle, counter frozen, prescaler held at 0
// RUN   | prescaler running, enable pulses every d cycles
// STEP  | single-cycle state emitting one enable pulse

module count_enable_gen_db #(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  output logic o_press
);
  localparam int DBC_W = $clog2(DB_CYCLES) + 1;
  localparam logic [DBC_W-1:0] DBC_MAX = DBC_W'(DB_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_db;
  logic             r_db_q;
  logic             r_press;
  logic [DBC_W-1:0] r_dbc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_db    <= 1'b0;
      r_db_q  <= 1'b0;
      r_press <= 1'b0;
      r_dbc   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      r_db_q  <= r_db;
      r_press <= r_db & ~r_db_q;
      // the level only moves after DB_CYCLES consecutive disagreeing samples
      if (r_sync2 == r_db) begin
        r_dbc <= '0;
      end else if (r_dbc == DBC_MAX) begin
        r_db  <= r_sync2;
        r_dbc <= '0;
      end else begin
        r_dbc <= r_dbc + 1'b1;
      end
    end
  end

  assign o_press = r_press;
endmodule

module count_enable_gen #(
  parameter int DB_CYCLES = 4,
  parameter int PRE_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run_btn,
  input  logic             step_btn,
  input  logic             clr_btn,
  input  logic [PRE_W-1:0] div,
  output logic             enable,
  output logic             cnt_clr,
  output logic             running
);
  localparam logic [1:0] ST_STOP = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_STEP = 2'd2;

  logic             w_p_run;
  logic             w_p_step;
  logic             w_p_clr;
  logic [PRE_W-1:0] w_dm1;

  logic [1:0]       r_state;
  logic [PRE_W-1:0] r_pc;
  logic             r_enable;
  logic             r_cnt_clr;
  logic             r_running;

  count_enable_gen_db #(.DB_CYCLES(DB_CYCLES)) u_db_run (
    .clk(clk), .reset(reset), .i_raw(run_btn), .o_press(w_p_run)
  );
  count_enable_gen_db #(.DB_CYCLES(DB_CYCLES)) u_db_step (
    .clk(clk), .reset(reset), .i_raw(step_btn), .o_press(w_p_step)
  );
  count_enable_gen_db #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
    .clk(clk), .reset(reset), .i_raw(clr_btn), .o_press(w_p_clr)
  );

  // terminal count d-1 with div==0 folded onto d==1
  assign w_dm1 = (div == '0) ? '0 : (div - 1'b1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_STOP;
      r_pc      <= '0;
      r_enable  <= 1'b0;
      r_cnt_clr <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_enable  <= 1'b0;
      r_cnt_clr <= w_p_clr;
      case (r_state)
        ST_STOP: begin
          r_pc <= '0;
          if (w_p_run) begin
            r_state   <= ST_RUN;
            r_running <= 1'b1;
          end else if (w_p_step) begin
            r_state  <= ST_STEP;
            r_enable <= 1'b1;
          end
        end
        ST_STEP: begin
          r_state <= ST_STOP;
          r_pc    <= '0;
        end
        ST_RUN: begin
          if (w_p_run) begin
            r_state   <= ST_STOP;
            r_running <= 1'b0;
            r_pc      <= '0;
          end else if (r_pc >= w_dm1) begin
            // >= rather than == so a shrinking div cannot let pc run past it
            r_pc     <= '0;
            r_enable <= 1'b1;
          end else begin
            r_pc <= r_pc + 1'b1;
          end
        end
        default: begin
          r_state   <= ST_STOP;
          r_running <= 1'b0;
          r_pc      <= '0;
        end
      endcase
    end
  end

  assign enable  = r_enable;
  assign cnt_clr = r_cnt_clr;
  assign running = r_running;
endmodule
